// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states,
// and the fixed read latency of the data RAM behind mem_ctrl.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MEM_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_WR   = 2'd3
  } lsu_state_t;

  // Loads allow B/H/W/BU/HU; stores allow only B/H/W.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge,
// byte-lane mask and access legality checks.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic        we_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o,
  output logic [3:0]  lane_mask_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'd0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'd0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

  always_comb begin
    store_word_o = rdata_i;
    lane_mask_o  = 4'hF;
    case (funct3_i[1:0])
      2'b00: begin
        store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
        lane_mask_o = 4'b0001 << addr_lo_i;
      end
      2'b01: begin
        store_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        lane_mask_o = 4'b0011 << {addr_lo_i[1], 1'b0};
      end
      default: begin
        store_word_o = wdata_i;
        lane_mask_o  = 4'hF;
      end
    endcase
  end

  always_comb begin
    misaligned_o = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0])
                || ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
    illegal_o    = f3_illegal(we_i, funct3_i);
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single outstanding request, registered memory-side
// strobes, read-modify-write for SB/SH against a word-only RAM.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        fault,
  output logic        read_from_memory,
  output logic        write_from_memory,
  output logic [31:0] memory_addr,
  output logic [31:0] data_to_write,
  output logic [3:0]  byte_enable_from_memory,
  input  logic [31:0] data_to_read
);

  lsu_state_t  state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        fault_q, fault_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] dtw_q, dtw_d;
  logic [3:0]  be_q, be_d;

  logic        idle;
  logic [1:0]  al_addr_lo;
  logic [2:0]  al_funct3;
  logic        al_we;
  logic [31:0] al_load_data;
  logic [31:0] al_store_word;
  logic [3:0]  al_lane_mask;
  logic        al_misaligned;
  logic        al_illegal;
  logic [31:0] req_word_addr;
  logic        unused_addr_hi;

  assign idle          = (state_q == ST_IDLE);
  assign req_word_addr = 32'(req_addr[MEM_AW+1:2]);
  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

  // One aligner serves both the accept-time check (live request) and the
  // capture-time formatting (registered request); idle selects which.
  assign al_addr_lo = idle ? req_addr[1:0] : addr_lo_q;
  assign al_funct3  = idle ? req_funct3    : funct3_q;
  assign al_we      = idle ? req_we        : we_q;

  lsu_align u_align (
    .addr_lo_i    (al_addr_lo),
    .funct3_i     (al_funct3),
    .we_i         (al_we),
    .rdata_i      (data_to_read),
    .wdata_i      (wdata_q),
    .load_data_o  (al_load_data),
    .store_word_o (al_store_word),
    .lane_mask_o  (al_lane_mask),
    .misaligned_o (al_misaligned),
    .illegal_o    (al_illegal)
  );

  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    fault_d     = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    maddr_d     = maddr_q;
    dtw_d       = dtw_q;
    be_d        = 4'h0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_lo_d = req_addr[1:0];
          funct3_d  = req_funct3;
          we_d      = req_we;
          wdata_d   = req_wdata;
          if (al_illegal || al_misaligned) begin
            fault_d = 1'b1;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d = ST_WR;
            wr_d    = 1'b1;
            maddr_d = req_word_addr;
            dtw_d   = req_wdata;
            be_d    = 4'hF;
          end else begin
            state_d = ST_RD;
            rd_d    = 1'b1;
            maddr_d = req_word_addr;
          end
        end
      end
      ST_RD: state_d = ST_CAP;
      ST_CAP: begin
        if (we_q) begin
          state_d = ST_WR;
          wr_d    = 1'b1;
          dtw_d   = al_store_word;
          be_d    = al_lane_mask;
        end else begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = al_load_data;
        end
      end
      ST_WR: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      fault_q     <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      maddr_q     <= '0;
      dtw_q       <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      fault_q     <= fault_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      maddr_q     <= maddr_d;
      dtw_q       <= dtw_d;
      be_q        <= be_d;
    end
  end

  assign req_ready               = idle;
  assign rsp_valid               = rsp_valid_q;
  assign rsp_rdata               = rsp_rdata_q;
  assign fault                   = fault_q;
  assign read_from_memory        = rd_q;
  assign write_from_memory       = wr_q;
  assign memory_addr             = maddr_q;
  assign data_to_write           = dtw_q;
  assign byte_enable_from_memory = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array RAM behind the DUT and a
// separate reference memory that predicts strobes and responses.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned MEM_AW = 12;
  localparam int unsigned NW     = 1 << MEM_AW;

  logic        clk, rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, fault;
  logic [31:0] rsp_rdata;
  logic        read_from_memory, write_from_memory;
  logic [31:0] memory_addr, data_to_write, data_to_read;
  logic [3:0]  byte_enable_from_memory;

  load_store_unit #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
    .read_from_memory(read_from_memory), .write_from_memory(write_from_memory),
    .memory_addr(memory_addr), .data_to_write(data_to_write),
    .byte_enable_from_memory(byte_enable_from_memory),
    .data_to_read(data_to_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM behind mem_ctrl: whole-word writes, MEM_RD_LAT = 1 registered read.
  logic [31:0] ram [NW];
  always @(posedge clk) begin
    if (write_from_memory) ram[memory_addr[MEM_AW-1:0]] <= data_to_write;
    if (read_from_memory)  data_to_read <= ram[memory_addr[MEM_AW-1:0]];
  end

  logic [31:0] ref_mem [NW];

  typedef struct { bit is_fault; bit is_load; logic [31:0] data; int unsigned cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] be; int unsigned cyc; } wr_t;
  typedef struct { logic [31:0] addr; int unsigned cyc; } rd_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rd_t  rd_q[$];

  int unsigned total = 0;
  int unsigned bad   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: legality, lane arithmetic and timing from the ISA rules.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit track);
    int unsigned n = 0;
    int unsigned acc, idx, off, size, sh;
    bit legal;
    logic [31:0] w, b, nw, bm;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    idx  = (addr >> 2) % NW;
    off  = addr % 4;
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sh = 8 * off;
    w  = ref_mem[idx];
    if (!legal || (off % size) != 0) begin
      if (track) rsp_q.push_back('{1'b1, 1'b0, 32'd0, acc + 1});
    end else if (!we) begin
      rd_q.push_back('{idx, acc + 1});
      b = w >> sh;
      case (f3)
        3'd0: b = {{24{b[7]}}, b[7:0]};
        3'd4: b = b & 32'hFF;
        3'd1: b = {{16{b[15]}}, b[15:0]};
        3'd5: b = b & 32'hFFFF;
        default: b = w;
      endcase
      if (track) rsp_q.push_back('{1'b0, 1'b1, b, acc + 3});
    end else if (f3 == 3'd2) begin
      if (track) begin
        wr_q.push_back('{idx, wd, 4'hF, acc + 1});
        rsp_q.push_back('{1'b0, 1'b0, 32'd0, acc + 2});
        ref_mem[idx] = wd;
      end
    end else begin
      rd_q.push_back('{idx, acc + 1});
      if (track) begin
        bm = (size == 1) ? 32'hFF : 32'hFFFF;
        nw = (w & ~(bm << sh)) | ((wd & bm) << sh);
        wr_q.push_back('{idx, nw, 4'((size == 1 ? 1 : 3) << off), acc + 3});
        rsp_q.push_back('{1'b0, 1'b0, 32'd0, acc + 4});
        ref_mem[idx] = nw;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int unsigned n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((rsp_q.size() + wr_q.size() + rd_q.size()) != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    check("drain_pending", rsp_q.size() + wr_q.size() + rd_q.size(), 32'd0);
  endtask

  rsp_t mr;
  wr_t  mw;
  rd_t  mrd;
  always @(negedge clk) begin
    if (rst) begin
      check("rd_wr_exclusive", read_from_memory & write_from_memory, 32'd0);
      check("fault_rsp_exclusive", fault & rsp_valid, 32'd0);
      if (read_from_memory) begin
        if (rd_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
        else begin
          mrd = rd_q.pop_front();
          check("rd_addr", memory_addr, mrd.addr);
          check("rd_cycle", cyc, mrd.cyc);
        end
      end
      if (write_from_memory) begin
        if (wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          mw = wr_q.pop_front();
          check("wr_addr", memory_addr, mw.addr);
          check("wr_data", data_to_write, mw.data);
          check("wr_be", byte_enable_from_memory, mw.be);
          check("wr_cycle", cyc, mw.cyc);
        end
      end else begin
        check("be_idle", byte_enable_from_memory, 32'd0);
      end
      if (rsp_valid || fault) begin
        if (rsp_q.size() == 0) check("unexpected_rsp_or_fault", 32'd1, 32'd0);
        else begin
          mr = rsp_q.pop_front();
          check("rsp_is_fault", fault, mr.is_fault);
          if (mr.is_load && rsp_valid) check("rsp_rdata", rsp_rdata, mr.data);
          check("rsp_cycle", cyc, mr.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < NW; i++) begin
      a = $urandom;
      ram[i] = a;
      ref_mem[i] = a;
    end
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 32'd1);
    check("reset_rsp_valid", rsp_valid, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_fault", fault, 32'd0);
    check("reset_rd", read_from_memory, 32'd0);
    check("reset_wr", write_from_memory, 32'd0);
    check("reset_maddr", memory_addr, 32'd0);
    check("reset_dtw", data_to_write, 32'd0);
    check("reset_be", byte_enable_from_memory, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Word store then load back.
    issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b1); idle_cycles(2);
    issue(1'b0, F3_W, 32'h10, 32'h0, 1'b1);        idle_cycles(4);
    // Byte and halfword RMW with signed/unsigned reads.
    issue(1'b1, F3_W,  32'h10, 32'h11223344, 1'b1); idle_cycles(2);
    issue(1'b1, F3_B,  32'h11, 32'h000000AA, 1'b1); idle_cycles(5);
    issue(1'b0, F3_B,  32'h11, 32'h0, 1'b1);        idle_cycles(4);
    issue(1'b0, F3_BU, 32'h11, 32'h0, 1'b1);        idle_cycles(4);
    issue(1'b1, F3_H,  32'h12, 32'h00008001, 1'b1); idle_cycles(5);
    issue(1'b0, F3_H,  32'h12, 32'h0, 1'b1);        idle_cycles(4);
    issue(1'b0, F3_HU, 32'h12, 32'h0, 1'b1);        idle_cycles(4);
    // Misaligned and illegal requests.
    issue(1'b0, F3_W,   32'h13, 32'h0, 1'b1); idle_cycles(2);
    issue(1'b1, F3_H,   32'h01, 32'h5, 1'b1); idle_cycles(2);
    issue(1'b0, 3'b011, 32'h20, 32'h0, 1'b1); idle_cycles(2);
    issue(1'b1, 3'b100, 32'h20, 32'h7, 1'b1); idle_cycles(2);
    drain();

    // Reset during the capture cycle of a byte store: no write may follow.
    issue(1'b1, F3_B, 32'h11, 32'h00000055, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_wr", write_from_memory, 32'd0);
    check("abort_ready", req_ready, 32'd1);
    check("abort_rsp", rsp_valid, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_wr_hold", write_from_memory, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    issue(1'b0, F3_W, 32'h10, 32'h0, 1'b1); idle_cycles(4);
    drain();

    // Back-to-back loads with req_valid held; 0x4010 aliases 0x10.
    issue(1'b0, F3_W, 32'h4010, 32'h0, 1'b1);
    issue(1'b0, F3_W, 32'h14, 32'h0, 1'b1);
    issue(1'b0, F3_W, 32'h18, 32'h0, 1'b1);
    idle_cycles(4);
    drain();

    // Random traffic over a small aliased window.
    for (int unsigned k = 0; k < 300; k++) begin
      a = ($urandom & 32'hFFFFC000) | (($urandom % 16) << 2) | ($urandom % 4);
      issue(1'(($urandom % 2)), 3'($urandom % 8), a, $urandom, 1'b1);
      if ($urandom % 3 == 0) idle_cycles(1 + $urandom % 3);
    end
    idle_cycles(6);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the RISC-V execute stage and `mem_ctrl`. It accepts one CPU memory request at a time and handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW. For loads it extracts and sign- or zero-extends the addressed lane. The data RAM behind `mem_ctrl` writes whole words only, so sub-word stores are done as read-modify-write. Misaligned and illegal accesses are trapped before any memory strobe is issued.

## Interface
Parameters:
- `MEM_AW`, 12: word-address width of the data RAM; word index = `req_addr[MEM_AW+1:2]`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: CPU request valid.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 of the load/store.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_ready` out 1: unit idle; a request is accepted when `req_valid & req_ready`.
- `rsp_valid` out 1: one-cycle completion pulse for loads and stores.
- `rsp_rdata` out 32: formatted load data; valid with `rsp_valid` for loads.
- `fault` out 1: one-cycle pulse for a misaligned or illegal request.
- `read_from_memory` out 1: read strobe to `mem_ctrl`.
- `write_from_memory` out 1: write strobe to `mem_ctrl`.
- `memory_addr` out 32: word address, zero-extended from `MEM_AW` bits.
- `data_to_write` out 32: full word to write.
- `byte_enable_from_memory` out 4: lanes modified by this write; informational, since the RAM writes the full word.
- `data_to_read` in 32: RAM read data.

## Operation
- States: IDLE, RD, CAP, WR. `req_ready` = (state == IDLE).
- On accept, the unit registers addr, funct3, we and wdata, then checks the request:
  - Illegal: load funct3 ∈ {011, 110, 111}; store funct3 ∉ {000, 001, 010}.
  - Misaligned: halfword with addr[0] = 1; word with addr[1:0] ≠ 0.
  - Illegal or misaligned: `fault` = 1 next cycle, state stays IDLE, no strobe, no `rsp_valid`.
- Load: IDLE → RD → CAP → IDLE.
  - RD: `read_from_memory` = 1, `memory_addr` driven.
  - CAP: the unit samples `data_to_read` and formats lane addr[1:0]. Byte lane k = bits [8k+7:8k]; halfword uses lane pair addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- SW: IDLE → WR → IDLE. In WR: `write_from_memory` = 1, `data_to_write` = wdata, byte enable = 4'hF.
- SB/SH: IDLE → RD → CAP → WR → IDLE.
  - CAP: merge wdata[7:0] or wdata[15:0] into the read word at the addressed lane(s).
  - WR: write the merged word; byte enable = lane mask (SB: 1 << addr[1:0]; SH: 4'b0011 << (2·addr[1])).
- Address width: bits above `MEM_AW+1` are ignored, so addresses alias modulo 2^(MEM_AW+2) bytes.
- Only one request is in flight; no write buffering.

## Timing
- Cycle 0 is the accept cycle. All outputs are registered.
- RAM read latency is fixed at 1: data for an address strobed in cycle n is valid in cycle n+1.
- Load: strobe in cycle 1, sample in cycle 2, `rsp_valid` + `rsp_rdata` in cycle 3.
- SW: write in cycle 1, `rsp_valid` in cycle 2.
- SB/SH: read in cycle 1, merge in cycle 2, write in cycle 3, `rsp_valid` in cycle 4.
- Fault: `fault` in cycle 1. `fault` and `rsp_valid` are never high together.
- `req_ready` returns high in the same cycle as `rsp_valid` or `fault`, so a new request may be accepted in that cycle.
- `read_from_memory` and `write_from_memory` are single-cycle and mutually exclusive.
- Outside strobes, `memory_addr` and `data_to_write` hold their last value, and byte enable = 0.
- Reset values: state IDLE; `req_ready` 1; all other outputs 0.
- Reset mid-operation: asynchronous clear to IDLE, strobes drop immediately. A pending RMW write is never issued (RAM keeps its old word), and no `rsp_valid` is produced for the aborted request.

## Structure
- Package `lsu_pkg`:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum `lsu_state_t`;
  - `MEM_RD_LAT` = 1.
- Sub-module `lsu_align` (combinational). Inputs: addr[1:0], funct3, read word, wdata. Outputs: extended load data, merged store word, lane mask, misaligned/illegal flags.
- Top level `load_store_unit`: FSM, request registers, memory-side output registers.

## Test plan
1. SW 0x10 ← 0xDEADBEEF, then LW 0x10 → one write strobe with `memory_addr` = 4, byte enable 4'hF; `rsp_rdata` = 0xDEADBEEF in cycle 3.
2. Word 0x10 = 0x11223344; SB 0x11 ← 0x000000AA → write data 0x1122AA44, byte enable 4'b0010, `rsp_valid` in cycle 4. Then LB 0x11 → 0xFFFFFFAA; LBU 0x11 → 0x000000AA.
3. SH 0x12 ← 0x8001 on 0x1122AA44 → write data 0x8001AA44, byte enable 4'b1100. Then LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001.
4. LW 0x13, SH 0x01, load funct3 011, store funct3 100 → each gives `fault` in cycle 1, no strobes, no `rsp_valid`.
5. Assert `rst` during CAP of an SB → `write_from_memory` never high, `req_ready` = 1; a later LW returns the unmodified word.
6. `req_valid` held high over three LWs (0x4010, 0x14, 0x18) → accepts 3 cycles apart, responses in order; 0x4010 returns the word at 0x10.
